// File: rtl/opseq_pkg.sv
// Shared types, ALU opcodes and flag helpers for the ALU op sequencer.
package opseq_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned CMD_W  = 3;

   typedef enum logic [CMD_W-1:0] {
      ADD16 = 3'd0,
      SUB16 = 3'd1,
      SHL16 = 3'd2,
      SHR16 = 3'd3,
      XOR16 = 3'd4
   } cmd_e;

   localparam logic [OP_W-1:0] ALU_SUB = 3'b000;
   localparam logic [OP_W-1:0] ALU_XOR = 3'b001;
   localparam logic [OP_W-1:0] ALU_SHL = 3'b010;
   localparam logic [OP_W-1:0] ALU_SHR = 3'b011;
   localparam logic [OP_W-1:0] ALU_ADD = 3'b100;

   typedef enum logic [2:0] {
      IDLE, LO, HI, FIX, SH_HI, SH_LO, RESP
   } state_e;

   // Byte-wise ALU opcode for the arithmetic/logic command families
   function automatic logic [OP_W-1:0] arith_op(input cmd_e cmd);
      case (cmd)
         SUB16:   return ALU_SUB;
         XOR16:   return ALU_XOR;
         default: return ALU_ADD;
      endcase
   endfunction

   // Carry (add) or borrow (sub) out of one byte op; xor never chains
   function automatic logic carry_flag(input cmd_e cmd, input logic [1:0] ovf);
      case (cmd)
         SUB16:   return (ovf != 2'b00);
         XOR16:   return 1'b0;
         default: return ovf[0];
      endcase
   endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Drives an external 8-bit ALU with byte/bit op sequences for 16-bit commands.
// OPSEQ_XOR16_EN enables cmd 100 as XOR16; otherwise it is rejected as illegal.
module alu_op_sequencer
   import opseq_pkg::*;
#(
   parameter int unsigned     SHAMT_BITS = 4,
   parameter logic [OP_W-1:0] IDLE_OP    = 3'b111
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [CMD_W-1:0]  req_cmd,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_carry,
   output logic              rsp_zero,
   output logic              rsp_err,
   output logic [OP_W-1:0]   alu_op,
   output logic [BYTE_W-1:0] alu_r1,
   output logic [BYTE_W-1:0] alu_r2,
   input  logic [BYTE_W-1:0] alu_out,
   input  logic [1:0]        alu_overflow
);

`ifdef OPSEQ_XOR16_EN
   localparam bit XOR_EN = 1'b1;
`else
   localparam bit XOR_EN = 1'b0;
`endif

   state_e                  state_q, state_nx;
   cmd_e                    cmd_q, cmd_nx;
   logic [BYTE_W-1:0]       a_hi_q, a_hi_nx, b_hi_q, b_hi_nx;
   logic [BYTE_W-1:0]       lo_q, lo_nx, hi_q, hi_nx;
   logic [SHAMT_BITS-1:0]   count_q, count_nx;
   logic                    low_flag_q, low_flag_nx, carry_q, carry_nx, err_q, err_nx;
   logic                    req_ready_nx, rsp_valid_nx, rsp_carry_nx, rsp_zero_nx, rsp_err_nx;
   logic [DATA_W-1:0]       rsp_result_nx;
   logic [OP_W-1:0]         alu_op_nx;
   logic [BYTE_W-1:0]       alu_r1_nx, alu_r2_nx;
   logic                    arith_cmd_c;

   assign arith_cmd_c = (req_cmd == 3'(ADD16)) || (req_cmd == 3'(SUB16)) ||
                        (XOR_EN && (req_cmd == 3'(XOR16)));

   // Next-state and next-output logic; ALU inputs idle unless a state issues an op
   always_comb begin
      state_nx      = state_q;
      cmd_nx        = cmd_q;
      a_hi_nx       = a_hi_q;
      b_hi_nx       = b_hi_q;
      lo_nx         = lo_q;
      hi_nx         = hi_q;
      count_nx      = count_q;
      low_flag_nx   = low_flag_q;
      carry_nx      = carry_q;
      err_nx        = err_q;
      req_ready_nx  = req_ready;
      rsp_valid_nx  = rsp_valid;
      rsp_result_nx = rsp_result;
      rsp_carry_nx  = rsp_carry;
      rsp_zero_nx   = rsp_zero;
      rsp_err_nx    = rsp_err;
      alu_op_nx     = IDLE_OP;
      alu_r1_nx     = '0;
      alu_r2_nx     = '0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               req_ready_nx = 1'b0;
               cmd_nx       = cmd_e'(req_cmd);
               a_hi_nx      = req_a[15:8];
               b_hi_nx      = req_b[15:8];
               lo_nx        = req_a[7:0];
               hi_nx        = req_a[15:8];
               count_nx     = req_b[SHAMT_BITS-1:0];
               low_flag_nx  = 1'b0;
               carry_nx     = 1'b0;
               err_nx       = 1'b0;
               if (arith_cmd_c) begin
                  state_nx  = LO;
                  alu_op_nx = arith_op(cmd_e'(req_cmd));
                  alu_r1_nx = req_b[7:0];
                  alu_r2_nx = req_a[7:0];
               end else if (req_cmd == 3'(SHL16) || req_cmd == 3'(SHR16)) begin
                  if (req_b[SHAMT_BITS-1:0] == '0) begin
                     state_nx = RESP;
                  end else if (req_cmd == 3'(SHL16)) begin
                     state_nx  = SH_HI;
                     alu_op_nx = ALU_SHL;
                     alu_r1_nx = req_a[7:0];
                     alu_r2_nx = req_a[15:8];
                  end else begin
                     state_nx  = SH_LO;
                     alu_op_nx = ALU_SHR;
                     alu_r1_nx = req_a[15:8];
                     alu_r2_nx = req_a[7:0];
                  end
               end else begin
                  state_nx = RESP;
                  err_nx   = 1'b1;
                  lo_nx    = '0;
                  hi_nx    = '0;
               end
            end
         end
         LO: begin
            lo_nx       = alu_out;
            low_flag_nx = carry_flag(cmd_q, alu_overflow);
            state_nx    = HI;
            alu_op_nx   = arith_op(cmd_q);
            alu_r1_nx   = b_hi_q;
            alu_r2_nx   = a_hi_q;
         end
         HI: begin
            hi_nx    = alu_out;
            carry_nx = carry_flag(cmd_q, alu_overflow);
            if (low_flag_q) begin
               state_nx  = FIX;
               alu_op_nx = arith_op(cmd_q);
               alu_r1_nx = 8'd1;
               alu_r2_nx = alu_out;
            end else begin
               state_nx = RESP;
            end
         end
         FIX: begin
            hi_nx    = alu_out;
            carry_nx = carry_q | carry_flag(cmd_q, alu_overflow);
            state_nx = RESP;
         end
         // SHL pairs run high then low; SHR pairs run low then high
         SH_HI: begin
            hi_nx = alu_out;
            if (cmd_q == SHL16) begin
               state_nx  = SH_LO;
               alu_op_nx = ALU_SHL;
               alu_r2_nx = lo_q;
            end else begin
               count_nx = count_q - SHAMT_BITS'(1);
               if (count_q == SHAMT_BITS'(1)) begin
                  state_nx = RESP;
               end else begin
                  state_nx  = SH_LO;
                  alu_op_nx = ALU_SHR;
                  alu_r1_nx = alu_out;
                  alu_r2_nx = lo_q;
               end
            end
         end
         SH_LO: begin
            lo_nx = alu_out;
            if (cmd_q == SHR16) begin
               state_nx  = SH_HI;
               alu_op_nx = ALU_SHR;
               alu_r2_nx = hi_q;
            end else begin
               count_nx = count_q - SHAMT_BITS'(1);
               if (count_q == SHAMT_BITS'(1)) begin
                  state_nx = RESP;
               end else begin
                  state_nx  = SH_HI;
                  alu_op_nx = ALU_SHL;
                  alu_r1_nx = alu_out;
                  alu_r2_nx = hi_q;
               end
            end
         end
         RESP: begin
            if (!rsp_valid) begin
               rsp_valid_nx  = 1'b1;
               rsp_result_nx = {hi_q, lo_q};
               rsp_carry_nx  = carry_q;
               rsp_zero_nx   = !err_q && ({hi_q, lo_q} == '0);
               rsp_err_nx    = err_q;
            end else if (rsp_ready) begin
               rsp_valid_nx  = 1'b0;
               rsp_result_nx = '0;
               rsp_carry_nx  = 1'b0;
               rsp_zero_nx   = 1'b0;
               rsp_err_nx    = 1'b0;
               req_ready_nx  = 1'b1;
               state_nx      = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cmd_q      <= ADD16;
         a_hi_q     <= '0;
         b_hi_q     <= '0;
         lo_q       <= '0;
         hi_q       <= '0;
         count_q    <= '0;
         low_flag_q <= 1'b0;
         carry_q    <= 1'b0;
         err_q      <= 1'b0;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
         alu_op     <= IDLE_OP;
         alu_r1     <= '0;
         alu_r2     <= '0;
      end else begin
         state_q    <= state_nx;
         cmd_q      <= cmd_nx;
         a_hi_q     <= a_hi_nx;
         b_hi_q     <= b_hi_nx;
         lo_q       <= lo_nx;
         hi_q       <= hi_nx;
         count_q    <= count_nx;
         low_flag_q <= low_flag_nx;
         carry_q    <= carry_nx;
         err_q      <= err_nx;
         req_ready  <= req_ready_nx;
         rsp_valid  <= rsp_valid_nx;
         rsp_result <= rsp_result_nx;
         rsp_carry  <= rsp_carry_nx;
         rsp_zero   <= rsp_zero_nx;
         rsp_err    <= rsp_err_nx;
         alu_op     <= alu_op_nx;
         alu_r1     <= alu_r1_nx;
         alu_r2     <= alu_r2_nx;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 8-bit ALU on the alu_* port.
module tb_alu_op_sequencer;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_cmd;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic        rsp_carry;
   logic        rsp_zero;
   logic        rsp_err;
   logic [2:0]  alu_op;
   logic [7:0]  alu_r1;
   logic [7:0]  alu_r2;
   logic [7:0]  alu_out;
   logic [1:0]  alu_overflow;
   logic [8:0]  sum9;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [2:0]  cmd;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] result;
      logic        carry;
      logic        zero;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs [17];

   alu_op_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_cmd      (req_cmd),
      .req_a        (req_a),
      .req_b        (req_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_carry    (rsp_carry),
      .rsp_zero     (rsp_zero),
      .rsp_err      (rsp_err),
      .alu_op       (alu_op),
      .alu_r1       (alu_r1),
      .alu_r2       (alu_r2),
      .alu_out      (alu_out),
      .alu_overflow (alu_overflow)
   );

   // ALU model: shifts funnel one bit in from R1; a sub borrow is flagged on OVERFLOW[1]
   always_comb begin
      alu_out      = '0;
      alu_overflow = '0;
      sum9         = '0;
      case (alu_op)
         3'b000: begin
            alu_out      = alu_r2 - alu_r1;
            alu_overflow = (alu_r1 > alu_r2) ? 2'b10 : 2'b00;
         end
         3'b001: alu_out = alu_r1 ^ alu_r2;
         3'b010: alu_out = {alu_r2[6:0], alu_r1[7]};
         3'b011: alu_out = {alu_r1[0], alu_r2[7:1]};
         3'b100: begin
            sum9         = {1'b0, alu_r1} + {1'b0, alu_r2};
            alu_out      = sum9[7:0];
            alu_overflow = {1'b0, sum9[8]};
         end
         default: ;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one command, measure latency from the accept edge, check the response
   task automatic run_vec(input int idx, input vec_t v);
      int lat;
      @(negedge clk);
      check($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_cmd   = v.cmd;
      req_a     = v.a;
      req_b     = v.b;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 0;
      for (int c = 1; c <= 64; c++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) begin
            lat = c;
            break;
         end
      end
      check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
      check($sformatf("v%0d result", idx), 32'(rsp_result), 32'(v.result));
      check($sformatf("v%0d carry", idx), 32'(rsp_carry), 32'(v.carry));
      check($sformatf("v%0d zero", idx), 32'(rsp_zero), 32'(v.zero));
      check($sformatf("v%0d err", idx), 32'(rsp_err), 32'(v.err));
      @(posedge clk);
      #1;
      check($sformatf("v%0d rsp_valid drop", idx), 32'(rsp_valid), 32'd0);
      check($sformatf("v%0d idle alu_op", idx), 32'(alu_op), 32'h7);
   endtask

   initial begin
      int lat;
      int rises;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_cmd   = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;

      vecs[0]  = '{3'd0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 4};
      vecs[1]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 4};
      vecs[2]  = '{3'd0, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 3};
      vecs[3]  = '{3'd1, 16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0, 1'b0, 4};
      vecs[4]  = '{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4};
      vecs[5]  = '{3'd2, 16'h8001, 16'h0004, 16'h0010, 1'b0, 1'b0, 1'b0, 9};
      vecs[6]  = '{3'd3, 16'h8001, 16'h0001, 16'h4000, 1'b0, 1'b0, 1'b0, 3};
      vecs[7]  = '{3'd2, 16'h8001, 16'h0000, 16'h8001, 1'b0, 1'b0, 1'b0, 1};
      vecs[8]  = '{3'd6, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
`ifdef OPSEQ_XOR16_EN
      vecs[9]  = '{3'd4, 16'h1234, 16'h00FF, 16'h12CB, 1'b0, 1'b0, 1'b0, 3};
`else
      vecs[9]  = '{3'd4, 16'h1234, 16'h00FF, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
`endif
      vecs[10] = '{3'd1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 3};
      vecs[11] = '{3'd3, 16'h8001, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 31};
      vecs[12] = '{3'd0, 16'h1280, 16'h0180, 16'h1400, 1'b0, 1'b0, 1'b0, 4};
      vecs[13] = '{3'd2, 16'h00FF, 16'h0009, 16'hFE00, 1'b0, 1'b0, 1'b0, 19};
      vecs[14] = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, 4};
      vecs[15] = '{3'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
      vecs[16] = '{3'd1, 16'h0001, 16'h0100, 16'hFF01, 1'b1, 1'b0, 1'b0, 3};

      repeat (2) @(posedge clk);
      #1;
      check("reset req_ready", 32'(req_ready), 32'd1);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset rsp_result", 32'(rsp_result), 32'd0);
      check("reset alu_op", 32'(alu_op), 32'h7);
      check("reset alu_r1", 32'(alu_r1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

      // Back-pressure: response held, nothing issued to the ALU, no early re-accept
      @(negedge clk);
      req_valid = 1'b1;
      req_cmd   = 3'd3;
      req_a     = 16'h8001;
      req_b     = 16'h0001;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 0;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) begin
            lat = c;
            break;
         end
      end
      check("hold latency", 32'(lat), 32'd3);
      req_valid = 1'b1;
      req_cmd   = 3'd0;
      req_a     = 16'h0001;
      req_b     = 16'h0001;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("hold%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
         check($sformatf("hold%0d rsp_result", k), 32'(rsp_result), 32'h4000);
         check($sformatf("hold%0d req_ready", k), 32'(req_ready), 32'd0);
         check($sformatf("hold%0d alu_op", k), 32'(alu_op), 32'h7);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("release rsp_valid", 32'(rsp_valid), 32'd0);
      check("release req_ready", 32'(req_ready), 32'd1);
      check("release no accept", 32'(alu_op), 32'h7);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("reaccept req_ready", 32'(req_ready), 32'd0);
      check("reaccept alu_op", 32'(alu_op), 32'h4);
      lat = 0;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) begin
            lat = c;
            break;
         end
      end
      check("reaccept latency", 32'(lat), 32'd3);
      check("reaccept result", 32'(rsp_result), 32'h0002);
      @(posedge clk);
      #1;

      // Reset in the middle of a long shift discards it
      @(negedge clk);
      req_valid = 1'b1;
      req_cmd   = 3'd2;
      req_a     = 16'h8001;
      req_b     = 16'h000F;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("midshift alu_op", 32'(alu_op), 32'h2);
      rst_n = 1'b0;
      #1;
      check("abort rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort req_ready", 32'(req_ready), 32'd1);
      check("abort alu_op", 32'(alu_op), 32'h7);
      check("abort alu_r2", 32'(alu_r2), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rises = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) rises++;
      end
      check("abort no response", 32'(rises), 32'd0);
      check("abort idle ready", 32'(req_ready), 32'd1);

      run_vec(99, vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
